// File: rtl/mproc_gen_if.sv
// Instruction-fetch bus between mproc_gen (master) and instruction memory (slave).
interface mproc_gen_if #(
  parameter int AW = 16
);
  logic [AW-1:0] addr;
  logic [15:0]   ins;
  logic          ins_valid;

  modport master (output addr, input ins, input ins_valid);
  modport slave  (input addr, output ins, output ins_valid);
endinterface

// File: rtl/mproc_gen.sv
// Multi-cycle FETCH/EXEC core with 8-entry register file, Z/C flags and HALT.
// Define MPROC_GEN_BRANCH_EN to implement JMP/BZ; otherwise they decode as NOP.
module mproc_gen #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset,
  mproc_gen_if.master   bus,
  output logic          halted,
  output logic          flag_z,
  output logic          flag_c,
  input  logic [2:0]    dbg_sel,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  typedef enum logic [4:0] {
    OP_ALU  = 5'b00000,
    OP_LDI  = 5'b00001,
    OP_JMP  = 5'b00010,
    OP_BZ   = 5'b00011,
    OP_HALT = 5'b11111
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [15:0]   ir;
  logic [DW-1:0] rf [8];

  opcode_t       opcode;
  alu_op_t       alu_op;
  logic [2:0]    wr, rb, ra;
  logic [DW-1:0] a, b, b_eff, imm_ext, alu_res;
  logic [DW:0]   sum;
  logic          alu_carry;
  logic [AW-1:0] pc_inc, pc_next;

  assign bus.addr = pc;
  assign dbg_data = rf[dbg_sel];

  always_comb begin
    opcode  = opcode_t'(ir[15:11]);
    alu_op  = alu_op_t'(ir[10:9]);
    wr      = ir[8:6];
    rb      = ir[5:3];
    ra      = ir[2:0];
    a       = rf[ra];
    b       = rf[rb];
    imm_ext = '0;
    imm_ext[5:0] = ir[5:0];

    // Subtract as a + ~b + 1 so C is the carry-out (1 = no borrow).
    b_eff = (alu_op == ALU_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{DW{1'b0}}, (alu_op == ALU_SUB)};

    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (alu_op)
      ALU_ADD, ALU_SUB: begin
        alu_res   = sum[DW-1:0];
        alu_carry = sum[DW];
      end
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      default: alu_res = '0;
    endcase
  end

`ifdef MPROC_GEN_BRANCH_EN
  logic [AW-1:0] target;

  always_comb begin
    target = '0;
    target[10:0] = ir[10:0];
    pc_inc = pc + {{(AW-1){1'b0}}, 1'b1};
    pc_next = pc_inc;
    if (opcode == OP_JMP) begin
      pc_next = target;
    end else if (opcode == OP_BZ && flag_z) begin
      pc_next = target;
    end
  end
`else
  always_comb begin
    pc_inc  = pc + {{(AW-1){1'b0}}, 1'b1};
    pc_next = pc_inc;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      halted <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        rf[i] <= '0;
      end
    end else begin
      unique case (state)
        S_FETCH: begin
          if (bus.ins_valid) begin
            ir    <= bus.ins;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_FETCH;
          // HALT keeps PC on its own address; every other opcode advances via pc_next.
          unique case (opcode)
            OP_ALU: begin
              rf[wr] <= alu_res;
              flag_z <= (alu_res == '0);
              flag_c <= alu_carry;
              pc     <= pc_next;
            end
            OP_LDI: begin
              rf[wr] <= imm_ext;
              flag_z <= (imm_ext == '0);
              flag_c <= 1'b0;
              pc     <= pc_next;
            end
            OP_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: pc <= pc_next;
          endcase
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
